// File: rtl/float_pkg.sv
// Shared binary32 field constants and packing helpers for the int<->float converters.
package float_pkg;

    localparam int unsigned FP_EXP_W  = 8;
    localparam int unsigned FP_FRAC_W = 23;
    localparam int unsigned FP_BIAS   = 127;

    // Exponent of a normalized 32-bit integer whose MSB sits at bit 31.
    localparam logic [FP_EXP_W-1:0] FP_INT32_EXP = FP_EXP_W'(FP_BIAS + 31);

    localparam logic [31:0] FP_POS_ZERO = 32'h0000_0000;

    function automatic logic [31:0] fp_pack(input logic                 s,
                                            input logic [FP_EXP_W-1:0]  e,
                                            input logic [FP_FRAC_W-1:0] f);
        return {s, e, f};
    endfunction

endpackage

// File: rtl/lzc32.sv
// Combinational 32-bit leading-zero counter built as a binary tree of 2-bit leaves.
module lzc32 (
    input  logic [31:0] in_i,
    output logic [4:0]  cnt_o,
    output logic        all_zero_o
);

    // Node i at level l covers bits [(i+1)*2^(l+1)-1 : i*2^(l+1)]; higher index is more significant.
    logic       zero_l [0:4][0:15];
    logic [4:0] cnt_l  [0:4][0:15];

    // Leaves, then pairwise merge: if the upper half is all zero, count = half width + lower count.
    always_comb begin
        for (int l = 0; l < 5; l++) begin
            for (int i = 0; i < 16; i++) begin
                zero_l[l][i] = 1'b0;
                cnt_l[l][i]  = '0;
            end
        end
        for (int i = 0; i < 16; i++) begin
            zero_l[0][i] = ~|in_i[2*i+1 -: 2];
            cnt_l[0][i]  = {4'b0, ~in_i[2*i+1]};
        end
        for (int l = 0; l < 4; l++) begin
            for (int i = 0; i < (8 >> l); i++) begin
                zero_l[l+1][i] = zero_l[l][2*i+1] & zero_l[l][2*i];
                cnt_l[l+1][i]  = zero_l[l][2*i+1] ? (cnt_l[l][2*i] | (5'd1 << (l + 1)))
                                                  : cnt_l[l][2*i+1];
            end
        end
    end

    assign cnt_o      = cnt_l[4][0];
    assign all_zero_o = zero_l[4][0];

endmodule

// File: rtl/int_to_float_pipelined.sv
// Three-stage int32 -> binary32 converter (round-to-nearest-even) with valid/ready on both sides.
module int_to_float_pipelined
    import float_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] input_a,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] output_z
);

    // Stage 1: sign / magnitude capture
    logic        v1_q, s1_sign_q, s1_zero_q;
    logic [31:0] s1_mag_q;
    // Stage 2: normalized mantissa and exponent
    logic                v2_q, s2_sign_q, s2_zero_q;
    logic [31:0]         s2_norm_q;
    logic [FP_EXP_W-1:0] s2_exp_q;
    // Stage 3: packed result
    logic        v3_q;
    logic [31:0] z_q;

    logic en1, en2, en3;
    logic [31:0] s1_mag_d, s2_norm_d, z_d;
    logic [FP_EXP_W-1:0] s2_exp_d;
    logic [4:0] lz;
    logic       lz_zero;

    // Stage loads when empty or when the stage after it is loading this cycle.
    always_comb begin
        en3 = ~v3_q | out_ready;
        en2 = ~v2_q | en3;
        en1 = ~v1_q | en2;
    end

    assign in_ready  = en1;
    assign out_valid = v3_q;
    assign output_z  = z_q;

    // S1: absolute value; 0x80000000 negates to itself, which is right as unsigned.
    always_comb begin
        s1_mag_d = input_a[31] ? (~input_a + 32'd1) : input_a;
    end

    lzc32 u_lzc (
        .in_i       (s1_mag_q),
        .cnt_o      (lz),
        .all_zero_o (lz_zero)
    );

    // S2: shift leading one to bit 31 and derive the biased exponent.
    always_comb begin
        s2_norm_d = s1_mag_q << lz;
        s2_exp_d  = FP_INT32_EXP - {3'b0, lz};
    end

    // S3: round-to-nearest-even on the 8 discarded bits; mantissa overflow bumps the exponent.
    always_comb begin
        logic [23:0] m;
        logic        g, r, sticky, up;
        logic [24:0] m25;
        logic [FP_EXP_W-1:0]  e;
        logic [FP_FRAC_W-1:0] f;
        m      = s2_norm_q[31:8];
        g      = s2_norm_q[7];
        r      = s2_norm_q[6];
        sticky = |s2_norm_q[5:0];
        up     = g & (r | sticky | m[0]);
        m25    = {1'b0, m} + {24'b0, up};
        e      = s2_exp_q;
        f      = m25[22:0];
        if (m25[24]) begin
            e = s2_exp_q + 8'd1;
            f = '0;
        end
        z_d = s2_zero_q ? FP_POS_ZERO : fp_pack(s2_sign_q, e, f);
    end

    // Stage registers; data only moves when a valid item enters the stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_q      <= 1'b0;
            s1_sign_q <= 1'b0;
            s1_zero_q <= 1'b0;
            s1_mag_q  <= '0;
            v2_q      <= 1'b0;
            s2_sign_q <= 1'b0;
            s2_zero_q <= 1'b0;
            s2_norm_q <= '0;
            s2_exp_q  <= '0;
            v3_q      <= 1'b0;
            z_q       <= FP_POS_ZERO;
        end else begin
            if (en1) begin
                v1_q <= in_valid;
                if (in_valid) begin
                    s1_sign_q <= input_a[31];
                    s1_zero_q <= (input_a == 32'd0);
                    s1_mag_q  <= s1_mag_d;
                end
            end
            if (en2) begin
                v2_q <= v1_q;
                if (v1_q) begin
                    s2_sign_q <= s1_sign_q;
                    // Both flags mark a zero operand; either suffices.
                    s2_zero_q <= s1_zero_q | lz_zero;
                    s2_norm_q <= s2_norm_d;
                    s2_exp_q  <= s2_exp_d;
                end
            end
            if (en3) begin
                v3_q <= v2_q;
                if (v2_q) begin
                    z_q <= z_d;
                end
            end
        end
    end

endmodule
